// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run/step execution controller.
// State values are fixed because the display decodes them directly.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } run_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/btn_debounce.sv
// Step button conditioning: two-flop synchronizer, stability debounce and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronized input disagrees with the
    // accepted level; any sample that agrees restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_q <= level;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/run_step_ctrl.sv
// Execution controller: converts divider ticks into a one-cycle Advance
// enable with free-run, single-step and PC-breakpoint halt modes.
module run_step_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             RunSw,
    input  logic             StepBtn,
    input  logic             BrkEn,
    input  logic [31:0]      BrkAddr,
    input  logic [31:0]      WB_PCAddResult,
    output logic             Advance,
    output logic             Halted,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] CycleCount
);

    run_state_t state_q;
    run_state_t state_d;
    logic       adv_d;
    logic       step_req;
    logic       mask;
    logic       hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (Clk),
        .reset (Reset),
        .btn   (StepBtn),
        .rise  (step_req)
    );

    assign hit = BrkEn & (WB_PCAddResult == BrkAddr) & ~mask;

    always_comb begin
        state_d = state_q;
        adv_d   = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (RunSw)         state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (!RunSw)        state_d = ST_HALT;
                else if (hit)      state_d = ST_BRK;
                else if (Tick)     adv_d   = 1'b1;
            end
            ST_STEP: begin
                if (Tick) begin
                    adv_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_BRK: begin
                if (!RunSw)        state_d = ST_HALT;
                else if (step_req) state_d = ST_STEP;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Mask suppresses the breakpoint until the first instruction retires after
    // (re)entering RUN, so execution can resume from the breakpoint PC.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_HALT;
            Advance    <= 1'b0;
            Halted     <= 1'b1;
            CycleCount <= '0;
            mask       <= 1'b1;
        end else begin
            state_q <= state_d;
            Advance <= adv_d;
            Halted  <= (state_d == ST_HALT) || (state_d == ST_BRK);
            if (Advance)
                CycleCount <= CycleCount + 1'b1;
            if (state_d == ST_RUN && state_q != ST_RUN)
                mask <= 1'b1;
            else if (Advance && state_q == ST_RUN)
                mask <= 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Self-checking bench for run_step_ctrl: run, step, breakpoint, counter wrap
// and mid-operation reset scenarios against a tick-counting reference model.
module tb_run_step_ctrl;

    localparam int DEB = 16;
    localparam int CW  = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Tick;
    logic          RunSw;
    logic          StepBtn;
    logic          BrkEn;
    logic [31:0]   BrkAddr;
    logic [31:0]   WB_PCAddResult;
    logic          Advance;
    logic          Halted;
    logic [1:0]    State;
    logic [CW-1:0] CycleCount;

    int checks = 0;
    int errors = 0;
    int exp_adv;            // advances the model expects since last reset
    logic [0:0] exp_q[$];   // expected Advance, one entry per driven cycle

    run_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Tick           (Tick),
        .RunSw          (RunSw),
        .StepBtn        (StepBtn),
        .BrkEn          (BrkEn),
        .BrkAddr        (BrkAddr),
        .WB_PCAddResult (WB_PCAddResult),
        .Advance        (Advance),
        .Halted         (Halted),
        .State          (State),
        .CycleCount     (CycleCount)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are stable when this returns.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Tick = 1'b0; RunSw = 1'b0; StepBtn = 1'b0;
        BrkEn = 1'b0; BrkAddr = 32'h0; WB_PCAddResult = 32'h0;
        cyc(); cyc();
        Reset = 1'b0;
        exp_adv = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (Advance !== 1'b0) begin errors++; $display("FAIL reset_advance got %0b exp 0", Advance); end
        checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %0b exp 1", Halted); end
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
        checks++; if (CycleCount !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", CycleCount); end
    endtask

    task automatic test_run();
        int n_adv;
        logic [0:0] e;
        do_reset();
        RunSw = 1'b1;
        cyc();
        checks++; if (State !== 2'd1 || Halted !== 1'b0) begin errors++; $display("FAIL run_enter state %0d halted %0b exp 1/0", State, Halted); end
        n_adv = 0;
        for (int i = 0; i < 40; i++) begin
            Tick = (i % 4 == 0);
            exp_q.push_back(Tick);
            if (Tick) exp_adv++;
            cyc();
            e = exp_q.pop_front();
            n_adv += int'(Advance);
            checks++; if (Advance !== e) begin errors++; $display("FAIL run_periodic_adv cyc %0d got %0b exp %0b", i, Advance, e); end
        end
        Tick = 1'b0;
        cyc();
        checks++; if (n_adv != 10) begin errors++; $display("FAIL run_pulse_count got %0d exp 10", n_adv); end
        checks++; if (CycleCount !== CW'(exp_adv)) begin errors++; $display("FAIL run_cycle_count got %0d exp %0d", CycleCount, exp_adv % 16); end
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL run_state got %0d exp 1", State); end
        // random tick pattern, including back-to-back ticks
        for (int i = 0; i < 30; i++) begin
            Tick = 1'($urandom_range(0, 1));
            exp_q.push_back(Tick);
            if (Tick) exp_adv++;
            cyc();
            e = exp_q.pop_front();
            checks++; if (Advance !== e) begin errors++; $display("FAIL run_random_adv cyc %0d got %0b exp %0b", i, Advance, e); end
        end
        Tick = 1'b0;
        cyc();
        checks++; if (CycleCount !== CW'(exp_adv)) begin errors++; $display("FAIL run_random_count got %0d exp %0d", CycleCount, exp_adv % 16); end
    endtask

    task automatic test_step();
        int n_adv;
        do_reset();
        // short bounce must never be accepted
        StepBtn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) StepBtn = 1'b0;
            Tick = 1'($urandom_range(0, 1));
            cyc();
            checks++; if ({State, Advance} !== 3'b000) begin errors++; $display("FAIL step_glitch cyc %0d state %0d adv %0b exp 0/0", i, State, Advance); end
        end
        Tick = 1'b0;
        StepBtn = 1'b1;
        repeat (2 + DEB) cyc();
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL step_early state %0d exp 0", State); end
        cyc();
        checks++; if (State !== 2'd2 || Halted !== 1'b0) begin errors++; $display("FAIL step_latency state %0d halted %0b exp 2/0", State, Halted); end
        // switch activity during a pending step is ignored
        RunSw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) RunSw = 1'b0;
            cyc();
            checks++; if (State !== 2'd2 || Advance !== 1'b0) begin errors++; $display("FAIL step_wait cyc %0d state %0d adv %0b exp 2/0", i, State, Advance); end
        end
        Tick = 1'b1;
        cyc();
        checks++; if (Advance !== 1'b1 || State !== 2'd0 || Halted !== 1'b1) begin errors++; $display("FAIL step_advance adv %0b state %0d halted %0b exp 1/0/1", Advance, State, Halted); end
        n_adv = 1;
        cyc();
        n_adv += int'(Advance);
        Tick = 1'b0;
        cyc(); cyc();
        checks++; if (n_adv != 1) begin errors++; $display("FAIL step_single got %0d advances exp 1", n_adv); end
        checks++; if (CycleCount !== 4'd1) begin errors++; $display("FAIL step_count got %0d exp 1", CycleCount); end
        StepBtn = 1'b0;
        repeat (DEB + 4) cyc();
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL step_release state %0d exp 0", State); end
    endtask

    task automatic test_brk();
        logic [0:0] e;
        do_reset();
        BrkEn = 1'b1; BrkAddr = 32'h0000_0010; WB_PCAddResult = 32'h0000_0020;
        RunSw = 1'b1;
        cyc();
        Tick = 1'b1; cyc(); exp_adv++;
        Tick = 1'b0; cyc();
        WB_PCAddResult = 32'h0000_0010; Tick = 1'b1;
        cyc();
        checks++; if (State !== 2'd3 || Halted !== 1'b1 || Advance !== 1'b0) begin errors++; $display("FAIL brk_hit state %0d halted %0b adv %0b exp 3/1/0", State, Halted, Advance); end
        cyc();
        checks++; if (State !== 2'd3 || Advance !== 1'b0) begin errors++; $display("FAIL brk_hold state %0d adv %0b exp 3/0", State, Advance); end
        Tick = 1'b0;
        RunSw = 1'b0; cyc();
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL brk_sw_off state %0d exp 0", State); end
        RunSw = 1'b1; cyc();
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL brk_resume state %0d exp 1", State); end
        Tick = 1'b1; cyc(); exp_adv++;
        checks++; if (State !== 2'd1 || Advance !== 1'b1) begin errors++; $display("FAIL brk_no_rehit state %0d adv %0b exp 1/1", State, Advance); end
        Tick = 1'b0; WB_PCAddResult = 32'h0000_0014;
        for (int i = 0; i < 12; i++) begin
            WB_PCAddResult = {$urandom_range(0, 255), 8'h00} | 32'h0000_0100;
            Tick = 1'($urandom_range(0, 1));
            exp_q.push_back(Tick);
            if (Tick) exp_adv++;
            cyc();
            e = exp_q.pop_front();
            checks++; if (Advance !== e || State !== 2'd1) begin errors++; $display("FAIL brk_miss_run cyc %0d adv %0b state %0d exp %0b/1", i, Advance, State, e); end
        end
        WB_PCAddResult = 32'h0000_0010; Tick = 1'b1;
        cyc();
        checks++; if (State !== 2'd3 || Advance !== 1'b0) begin errors++; $display("FAIL brk_rehit state %0d adv %0b exp 3/0", State, Advance); end
        Tick = 1'b0;
        StepBtn = 1'b1;
        repeat (3 + DEB) cyc();
        checks++; if (State !== 2'd2) begin errors++; $display("FAIL brk_step_enter state %0d exp 2", State); end
        Tick = 1'b1; cyc(); exp_adv++;
        checks++; if (Advance !== 1'b1 || State !== 2'd0) begin errors++; $display("FAIL brk_step_adv adv %0b state %0d exp 1/0", Advance, State); end
        Tick = 1'b0; RunSw = 1'b0; StepBtn = 1'b0;
        cyc(); cyc();
        checks++; if (CycleCount !== CW'(exp_adv)) begin errors++; $display("FAIL brk_count got %0d exp %0d", CycleCount, exp_adv % 16); end
        repeat (DEB + 4) cyc();
    endtask

    task automatic test_wrap();
        do_reset();
        RunSw = 1'b1;
        cyc();
        for (int k = 0; k < 17; k++) begin
            Tick = 1'b1; cyc(); exp_adv++;
            Tick = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
            if (k == 15) begin
                cyc(); cyc();
                checks++; if (CycleCount !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", CycleCount); end
            end
        end
        cyc(); cyc();
        checks++; if (CycleCount !== 4'd1 || exp_adv != 17) begin errors++; $display("FAIL wrap_17 got %0d exp 1", CycleCount); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        RunSw = 1'b1;
        cyc();
        Tick = 1'b1; cyc();
        Tick = 1'b0; Reset = 1'b1; cyc();
        checks++; if ({Advance, Halted, State, CycleCount} !== {1'b0, 1'b1, 2'd0, 4'd0}) begin errors++; $display("FAIL reset_mid adv %0b halted %0b state %0d cnt %0d exp 0/1/0/0", Advance, Halted, State, CycleCount); end
        Reset = 1'b0; cyc(); cyc();
        Tick = 1'b1; Reset = 1'b1; cyc();
        checks++; if ({Advance, Halted, State} !== {1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL reset_inflight adv %0b halted %0b state %0d exp 0/1/0", Advance, Halted, State); end
        Reset = 1'b0; Tick = 1'b0; RunSw = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_brk();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
